mmio_led_btn: RTL

MMIO_LED_BTN -- requirements
Module: mmio_led_btn

---
 rtl/mmio_led_btn.sv | 99 +++++++++
 1 files changed

// File: rtl/mmio_led_btn.sv
// Memory-mapped LED output register and debounced push-button status register.
// Buttons are synchronized and debounced per bit; rising edges latch sticky pressed flags.

module mmio_led_btn_db #(
   parameter int DB_CNT = 20'd500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise
);
   localparam int CW = $clog2(DB_CNT);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          settle;

   // Level has differed for DB_CNT consecutive edges: accept it on this edge.
   assign settle = (sync[1] != stable) && (cnt == CNT_MAX);
   assign rise   = settle && sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= '0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (settle) begin
            stable <= sync[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module mmio_led_btn #(
   parameter int N_LED  = 16,
   parameter int N_BTN  = 4,
   parameter int DB_CNT = 20'd500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      addr_in,
   input  logic             led_io,
   input  logic             wr_en,
   input  logic [31:0]      wr_data,
   input  logic             rd_en,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic [N_LED-1:0] led,
   input  logic [N_BTN-1:0] btn_in
);
   localparam logic [31:0] BTN_ADDR = 32'h0000_4004;

   logic [N_BTN-1:0] stable, rise, pressed, clr;
   logic             led_rd, btn_rd;
   logic [31:0]      led_word, btn_word;
   logic             unused_ok;

   assign unused_ok = &{1'b0, wr_data};

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      mmio_led_btn_db #(.DB_CNT(DB_CNT)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_in[g]),
         .stable(stable[g]),
         .rise  (rise[g])
      );
   end

   assign led_rd   = rd_en && led_io;
   assign btn_rd   = rd_en && !led_io && (addr_in == BTN_ADDR);
   assign led_word = 32'(led);
   assign btn_word = 32'(stable) | (32'(pressed) << 16);
   // Only the flags actually returned are cleared; a same-edge rise still sets.
   assign clr      = btn_rd ? pressed : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led      <= '0;
         pressed  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= led_rd || btn_rd;
         rd_data  <= led_rd ? led_word : (btn_rd ? btn_word : '0);
         pressed  <= (pressed & ~clr) | rise;
         if (wr_en && led_io) led <= wr_data[N_LED-1:0];
      end
   end
endmodule
